countdown_timer_bcd: RTL and testbench

COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_down_digit.sv | 31 +++
 rtl/countdown_timer_bcd.sv | 115 +++++++++++
 tb/tb_countdown_timer_bcd.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer.
// Holds the FSM state type, the digit width and the per-digit maxima.
// Also provides a helper that returns the maximum for a given digit position.
package timer_pkg;

  localparam int DIGIT_W = 4;

  // Largest value a digit may hold: decimal digits reach 9. In mm:ss mode the
  // tens-of-seconds digit only reaches 5.
  localparam logic [DIGIT_W-1:0] DIGIT_MAX      = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Maximum for digit position idx. Digit 1 is tens of seconds when mmss is set.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx, input bit mmss);
    return (mmss && idx == 1) ? DIGIT_MAX_TENS : DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load, clamp and borrow.
// Ports: clock, clearn (sync active-low); load/value preset (clamped to MAX);
//        dec decrements; q current digit; borrow is high when dec hits a 0 digit.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX
) (
  input  logic               clock,
  input  logic               clearn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] value,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow
);

  // A 0 digit that is decremented reloads MAX and passes the borrow upward.
  assign borrow = dec && (q == '0);

  always_ff @(posedge clock) begin
    if (!clearn) begin
      q <= '0;
    end else if (load) begin
      q <= (value > MAX) ? MAX : value;
    end else if (dec) begin
      q <= (q == '0) ? MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer: a borrow chain of digits controlled by an IDLE/RUN/PAUSE/DONE FSM.
// Ports: clock, clearn (sync active-low); data/loadn preset; start, stop, tick control;
//        digits (registered), zero (combinational), running, done, load_err (registered).
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MMSS_MODE  = 1
) (
  input  logic                      clock,
  input  logic                      clearn,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic                      loadn,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      tick,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic                      zero,
  output logic                      running,
  output logic                      done,
  output logic                      load_err
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  state_t          state;
  state_t          state_nxt;
  logic            load_all;
  logic [W-1:0]    load_val;
  logic            do_dec;
  logic            last_dec;
  logic [NUM_DIGITS-1:0] dec_chain;
  logic [NUM_DIGITS-1:0] borrow_out;
  logic            unused_top_borrow;

  assign zero = (digits == '0);

  // Ticks count only in RUN. The zero guard keeps the value from wrapping.
  assign do_dec   = (state == RUN) && tick && !zero;
  // The decrement that lands on zero is the one applied to a value of exactly 1.
  assign last_dec = do_dec && (digits == {{(W-1){1'b0}}, 1'b1});

  // The borrow of digit k decrements digit k+1.
  assign dec_chain[0] = do_dec;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_chain
    assign dec_chain[k] = borrow_out[k-1];
  end
  // The top digit never borrows because counting stops at zero.
  assign unused_top_borrow = borrow_out[NUM_DIGITS-1];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    bcd_down_digit #(
      .MAX (digit_max(k, MMSS_MODE != 0))
    ) u_digit (
      .clock  (clock),
      .clearn (clearn),
      .load   (load_all),
      .value  (load_val[k*DIGIT_W +: DIGIT_W]),
      .dec    (dec_chain[k]),
      .q      (digits[k*DIGIT_W +: DIGIT_W]),
      .borrow (borrow_out[k])
    );
  end

  always_comb begin
    state_nxt = state;
    load_all  = 1'b0;
    load_val  = data;
    case (state)
      IDLE: begin
        if (start && !zero) state_nxt = RUN;
      end
      RUN: begin
        // The final tick wins over a simultaneous stop.
        if (last_dec)  state_nxt = DONE;
        else if (stop) state_nxt = PAUSE;
      end
      PAUSE: begin
        // A stop while paused cancels the countdown and clears the value.
        if (stop) begin
          state_nxt = IDLE;
          load_all  = 1'b1;
          load_val  = '0;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    // A load outside RUN overrides everything else and parks the FSM in IDLE.
    if (!loadn && state != RUN) begin
      load_all  = 1'b1;
      load_val  = data;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state    <= IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == RUN);
      done     <= last_dec;
      load_err <= (state == RUN) && !loadn;
    end
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with NUM_DIGITS=4, MMSS_MODE=1.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// Expected values are hand-computed BCD constants.
module tb_countdown_timer_bcd;
  import timer_pkg::*;

  logic        clock = 1'b0;
  logic        clearn;
  logic [15:0] data;
  logic        loadn;
  logic        start;
  logic        stop;
  logic        tick;
  logic [15:0] digits;
  logic        zero;
  logic        running;
  logic        done;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  countdown_timer_bcd #(
    .NUM_DIGITS (4),
    .MMSS_MODE  (1)
  ) dut (
    .clock    (clock),
    .clearn   (clearn),
    .data     (data),
    .loadn    (loadn),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .digits   (digits),
    .zero     (zero),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    loadn = 1'b0;
    data  = d;
    step();
    loadn = 1'b1;
  endtask

  initial begin
    clearn = 1'b0; data = '0; loadn = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    step();
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    clearn = 1'b1;

    // Countdown 01:30 -> 01:29 -> 01:28
    load(16'h0130);
    chk("ld0130", 32'(digits), 32'h0130);
    start = 1'b1; step(); start = 1'b0;
    chk("run_running", 32'(running), 1);
    chk("run_state", 32'(dut.state), 32'(RUN));
    tick = 1'b1; step();
    chk("dec0129", 32'(digits), 32'h0129);
    step();
    chk("dec0128", 32'(digits), 32'h0128);
    chk("dec_running", 32'(running), 1);
    tick = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("pause_running", 32'(running), 0);

    // 01:00 -> 00:59, tick on the start edge ignored
    load(16'h0100);
    chk("ld_from_pause_state", 32'(dut.state), 32'(IDLE));
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    chk("start_tick_ignored", 32'(digits), 32'h0100);
    chk("start_running", 32'(running), 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("dec0059", 32'(digits), 32'h0059);
    stop = 1'b1; step(); step(); stop = 1'b0;
    chk("cancel_digits", 32'(digits), 32'h0000);
    chk("cancel_state", 32'(dut.state), 32'(IDLE));

    // 00:02 to zero; stop on the final tick is ignored
    load(16'h0002);
    start = 1'b1; step(); start = 1'b0;
    tick = 1'b1; step();
    chk("dec0001", 32'(digits), 32'h0001);
    chk("done_early", 32'(done), 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("final_digits", 32'(digits), 32'h0000);
    chk("final_zero", 32'(zero), 1);
    chk("final_done", 32'(done), 1);
    chk("final_state", 32'(dut.state), 32'(DONE));
    chk("final_running", 32'(running), 0);
    step(); tick = 1'b0;
    chk("done_pulse_end", 32'(done), 0);
    chk("no_wrap", 32'(digits), 32'h0000);
    start = 1'b1; step(); start = 1'b0;
    chk("done_start_ign", 32'(dut.state), 32'(DONE));
    chk("done_start_run", 32'(running), 0);

    // Pause holds value, second stop cancels
    load(16'h0045);
    chk("ld_from_done", 32'(dut.state), 32'(IDLE));
    start = 1'b1; step(); start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("pause_state", 32'(dut.state), 32'(PAUSE));
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    chk("pause_hold", 32'(digits), 32'h0045);
    stop = 1'b1; step(); stop = 1'b0;
    chk("pause_cancel", 32'(digits), 32'h0000);
    chk("pause_cancel_st", 32'(dut.state), 32'(IDLE));

    // Load during RUN rejected, then clamped load in IDLE
    load(16'h0300);
    start = 1'b1; step(); start = 1'b0;
    load(16'h0977);
    chk("lerr_pulse", 32'(load_err), 1);
    chk("lerr_digits", 32'(digits), 32'h0300);
    chk("lerr_running", 32'(running), 1);
    step();
    chk("lerr_end", 32'(load_err), 0);
    tick = 1'b1; step(); tick = 1'b0;
    chk("lerr_continue", 32'(digits), 32'h0259);
    stop = 1'b1; step(); step(); stop = 1'b0;
    load(16'h0A7B);
    chk("clamp_0959", 32'(digits), 32'h0959);
    load(16'h0977);
    chk("clamp_0957", 32'(digits), 32'h0957);

    // Reset mid-RUN with every other input active
    start = 1'b1; step(); start = 1'b0;
    chk("pre_rst_running", 32'(running), 1);
    clearn = 1'b0; tick = 1'b1; start = 1'b1; loadn = 1'b0; data = 16'h0555;
    step();
    clearn = 1'b1; tick = 1'b0; start = 1'b0; loadn = 1'b1;
    chk("mid_rst_digits", 32'(digits), 32'h0000);
    chk("mid_rst_running", 32'(running), 0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_zero", 32'(zero), 1);
    chk("mid_rst_lerr", 32'(load_err), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("zero_start_ign", 32'(dut.state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
